// File: rtl/lab_pkg.sv
// Shared types and helpers for the front-panel parameter editor.
package lab_pkg;

    typedef enum logic [1:0] {
        ST_FX    = 2'd0,
        ST_PARAM = 2'd1,
        ST_EDIT  = 2'd2
    } edit_state_t;

    // Mid-scale power-up value for a parameter of width w.
    function automatic int unsigned param_default(input int unsigned w);
        return 32'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/param_edit_ctrl_key_repeat.sv
// Rising-edge detector plus hold/auto-repeat timer producing single-cycle step pulses.
module key_repeat #(
    parameter int unsigned HOLD_CYCLES   = 25_000_000,
    parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    input  logic clr,
    output logic step
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYCLES);
    // Reloading here makes the next HOLD_VAL hit land REPEAT_CYCLES later; the counter never wraps.
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(HOLD_CYCLES - REPEAT_CYCLES + 1);

    logic             key_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        if (!key || clr) begin
            cnt_d = '0;
        end else if (!key_q) begin
            step  = 1'b1;
            cnt_d = CNT_W'(1);
        end else if (cnt_q == HOLD_VAL) begin
            step  = 1'b1;
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            key_q <= key;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/param_edit_ctrl.sv
// Front-panel edit sequencer: effect/parameter navigation, parameter bank and DSP write strobe.
module param_edit_ctrl
    import lab_pkg::*;
#(
    parameter int unsigned FX_COUNT      = 16,
    parameter int unsigned PARAM_COUNT   = 8,
    parameter int unsigned PARAM_W       = 7,
    parameter int unsigned HOLD_CYCLES   = 25_000_000,
    parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              key_up,
    input  logic                                              key_down,
    input  logic                                              key_next,
    input  logic                                              key_back,
    input  logic                                              sw_lock,
    output logic [$clog2(FX_COUNT)-1:0]                       fx_sel,
    output logic [$clog2(PARAM_COUNT)-1:0]                    param_sel,
    output logic [PARAM_W-1:0]                                current_value,
    output logic [1:0]                                        edit_state,
    output logic                                              wr_valid,
    output logic [$clog2(FX_COUNT)+$clog2(PARAM_COUNT)-1:0]   wr_addr,
    output logic [PARAM_W-1:0]                                wr_data
);

    localparam int unsigned FX_W   = $clog2(FX_COUNT);
    localparam int unsigned PS_W   = $clog2(PARAM_COUNT);
    localparam int unsigned ADDR_W = FX_W + PS_W;
    localparam int unsigned DEPTH  = FX_COUNT * PARAM_COUNT;
    localparam logic [FX_W-1:0]    FX_LAST   = FX_W'(FX_COUNT - 1);
    localparam logic [PS_W-1:0]    PS_LAST   = PS_W'(PARAM_COUNT - 1);
    localparam logic [PARAM_W-1:0] VAL_MAX   = '1;
    localparam logic [PARAM_W-1:0] VAL_RESET = PARAM_W'(param_default(PARAM_W));

    edit_state_t         state_q, state_d;
    logic [FX_W-1:0]     fx_q, fx_d;
    logic [PS_W-1:0]     ps_q, ps_d;
    logic [PARAM_W-1:0]  bank_q [DEPTH];
    logic                bank_we;
    logic [PARAM_W-1:0]  bank_wdata;
    logic                wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [PARAM_W-1:0]  wr_data_q, wr_data_d;
    logic                next_q, back_q;
    logic                next_rise, back_rise;
    logic                up_step, dn_step, ud_clr;
    logic [ADDR_W-1:0]   rd_addr;
    logic [PARAM_W-1:0]  cur_val;

    assign next_rise = key_next & ~next_q;
    assign back_rise = key_back & ~back_q;
    assign ud_clr    = key_up & key_down;
    assign rd_addr   = {fx_q, ps_q};
    assign cur_val   = bank_q[rd_addr];

    key_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_rep_up (
        .clk(clk), .rst_n(rst_n), .key(key_up), .clr(ud_clr), .step(up_step)
    );

    key_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_rep_dn (
        .clk(clk), .rst_n(rst_n), .key(key_down), .clr(ud_clr), .step(dn_step)
    );

    // Back (when it can move) beats next, which beats any up/down step.
    always_comb begin
        state_d    = state_q;
        fx_d       = fx_q;
        ps_d       = ps_q;
        bank_we    = 1'b0;
        bank_wdata = cur_val;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (back_rise && state_q != ST_FX) begin
            state_d = (state_q == ST_EDIT) ? ST_PARAM : ST_FX;
        end else if (next_rise) begin
            state_d = (state_q == ST_FX) ? ST_PARAM :
                      (state_q == ST_PARAM) ? ST_EDIT : ST_PARAM;
        end else if (up_step || dn_step) begin
            case (state_q)
                ST_FX: begin
                    if (up_step) fx_d = (fx_q == FX_LAST) ? '0 : fx_q + FX_W'(1);
                    else         fx_d = (fx_q == '0) ? FX_LAST : fx_q - FX_W'(1);
                end
                ST_PARAM: begin
                    if (up_step) ps_d = (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
                    else         ps_d = (ps_q == '0) ? PS_LAST : ps_q - PS_W'(1);
                end
                ST_EDIT: begin
                    if (!sw_lock) begin
                        if (up_step && cur_val != VAL_MAX) begin
                            bank_we    = 1'b1;
                            bank_wdata = cur_val + PARAM_W'(1);
                        end else if (dn_step && cur_val != '0) begin
                            bank_we    = 1'b1;
                            bank_wdata = cur_val - PARAM_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        if (bank_we) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = rd_addr;
            wr_data_d  = bank_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_FX;
            fx_q       <= '0;
            ps_q       <= '0;
            next_q     <= 1'b0;
            back_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) bank_q[i] <= VAL_RESET;
        end else begin
            state_q    <= state_d;
            fx_q       <= fx_d;
            ps_q       <= ps_d;
            next_q     <= key_next;
            back_q     <= key_back;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            if (bank_we) bank_q[rd_addr] <= bank_wdata;
        end
    end

    assign fx_sel        = fx_q;
    assign param_sel     = ps_q;
    assign current_value = cur_val;
    assign edit_state    = state_q;
    assign wr_valid      = wr_valid_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;

endmodule

// File: doc/param_edit_ctrl.md
# param_edit_ctrl

Front-panel controller that sequences parameter editing for the effects processor. Four push-button levels move through a three-state FSM: select effect, select parameter, edit value. The block owns the parameter register bank (FX_COUNT × PARAM_COUNT values). It drives `fx_sel`, `param_sel` and `current_value` to the display block, and emits a one-cycle write strobe toward the DSP configuration path.

## Interface
Parameters:
- `FX_COUNT`, 16: number of effects.
- `PARAM_COUNT`, 8: parameters per effect.
- `PARAM_W`, 7: parameter value width.
- `HOLD_CYCLES`, 25_000_000: cycles a key must be held before auto-repeat starts.
- `REPEAT_CYCLES`, 5_000_000: cycles between auto-repeat steps.

Ports (key inputs are active-high levels, already synchronized and debounced upstream):
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `key_up` in 1: increment.
- `key_down` in 1: decrement.
- `key_next` in 1: advance FSM.
- `key_back` in 1: retreat FSM.
- `sw_lock` in 1: when high, value edits are blocked; navigation still works.
- `fx_sel` out clog2(FX_COUNT): selected effect.
- `param_sel` out clog2(PARAM_COUNT): selected parameter.
- `current_value` out PARAM_W: `bank[fx_sel][param_sel]`.
- `edit_state` out 2: current FSM state (`edit_state_t`).
- `wr_valid` out 1: one-cycle strobe, asserted when a stored value changes.
- `wr_addr` out clog2(FX_COUNT)+clog2(PARAM_COUNT): `{fx_sel, param_sel}` of the write.
- `wr_data` out PARAM_W: the new value.

## Operation
- FSM states: `ST_FX`, `ST_PARAM`, `ST_EDIT`. Reset state is `ST_FX`.
- Rising edge of `key_next`: `ST_FX`→`ST_PARAM`→`ST_EDIT`. In `ST_EDIT` it returns to `ST_PARAM`.
- Rising edge of `key_back`: `ST_EDIT`→`ST_PARAM`→`ST_FX`. In `ST_FX` it has no effect.
- `key_next` and `key_back` act on the rising edge only; they never repeat.
- `key_up` and `key_down` produce a step on the rising edge. While held, a further step occurs after HOLD_CYCLES, then one every REPEAT_CYCLES.
- Effect of a step by state:
  - `ST_FX`: `fx_sel` ±1, wraps modulo FX_COUNT.
  - `ST_PARAM`: `param_sel` ±1, wraps modulo PARAM_COUNT.
  - `ST_EDIT`: value ±1, saturating at 0 and at 2^PARAM_W−1. Blocked while `sw_lock` is high.
- Changing `fx_sel` does not reset `param_sel`.
- Simultaneous events, in priority order:
  1. `key_back` rising.
  2. `key_next` rising.
  3. An up/down step.
  - If `key_up` and `key_down` are both high, neither steps, and both repeat counters clear.
  - An FSM transition in the same cycle as an up/down step discards the step.
- Write strobe: `wr_valid` pulses only when the stored value actually changes. A saturated or locked step produces no strobe.
- Reset values:
  - State is `ST_FX`; `fx_sel` = 0; `param_sel` = 0.
  - All bank entries are `PARAM_DEFAULT` (2^(PARAM_W−1), i.e. 64 at W=7).
  - `wr_valid` = 0, `wr_addr` = 0, `wr_data` = 0.
  - Repeat counters are 0.
- Reset asserted mid-hold or mid-edit restores every value above on the next clock edge.

## Timing
- All outputs are registered.
- Key rising edge at cycle N → updated `fx_sel`/`param_sel`/`current_value`/`edit_state` visible at cycle N+1.
- When a write occurs, `wr_valid`, `wr_addr` and `wr_data` are also visible at N+1, coincident with the new `current_value`.
- `current_value` always matches the bank entry addressed by the registered selectors. There is no extra read latency.
- Auto-repeat with a key high from cycle N:
  - First step at cycle N.
  - Second step at N+HOLD_CYCLES.
  - Subsequent steps at N+HOLD_CYCLES+k·REPEAT_CYCLES.
- Releasing the key clears its counter immediately.
- Repeat counters must be wide enough for HOLD_CYCLES. They must not wrap during long holds, so they saturate in the repeat phase.

## Structure
- `lab_pkg` additions:
  - `edit_state_t` enum (`ST_FX`=0, `ST_PARAM`=1, `ST_EDIT`=2).
  - `PARAM_DEFAULT` as a function of PARAM_W.
- Sub-module `key_repeat`:
  - Ports: `clk`, `rst_n`, `key`, `clr` → `step` pulse.
  - Contains the edge detector and the hold/repeat counter.
  - Instantiated twice, once for up and once for down.
- `key_next`/`key_back` edge detection lives inline.
- Bank storage: a register array, flop-based, with a single write port.

## Test plan
Bench uses HOLD_CYCLES=8, REPEAT_CYCLES=4.
- **Reset:** drive `rst_n` low 2 cycles → `edit_state`=ST_FX, `fx_sel`=0, `param_sel`=0, `current_value`=64, `wr_valid`=0.
- **Wrap:** in ST_FX, pulse `key_down` once → `fx_sel`=15. Then pulse `key_next`, then `key_down` → `param_sel`=7.
- **Edit:**
  - Navigate to fx 3, param 2, enter ST_EDIT, pulse `key_up` → `current_value`=65 and `wr_valid` for 1 cycle with `wr_addr`={3,2}, `wr_data`=65.
  - Then `key_back`, select fx 4 → `current_value`=64.
- **Saturation and lock:**
  - Hold `key_up` for 300 cycles in ST_EDIT → value reaches 127 and stays. No `wr_valid` after the value reaches 127.
  - With `sw_lock`=1, pulse `key_down` → value and `wr_valid` unchanged.
- **Repeat cadence:** hold `key_up` from cycle 0 for 20 cycles in ST_EDIT → steps at cycles 0, 8, 12, 16 (value +4). Holding `key_up` and `key_down` together → no steps.
- **Priority and mid-reset:**
  - `key_next` and `key_up` rise in the same cycle in ST_PARAM → state ST_EDIT, `param_sel` unchanged.
  - Assert `rst_n`=0 mid-repeat → all reset values on the next cycle.
